// File: rtl/i2s_rx_frame_ctrl.sv
// Master-mode frame sequencer for the 64x I2S receiver.
// Drives lrclk, gates start/stop on frame edges and queues tagged samples.
module i2s_rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_BCLKS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  rst,
  input  logic                  bclk,
  input  logic                  enable,
  output logic                  lrclk,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  left_valid,
  input  logic                  right_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  running,
  output logic [15:0]           frame_count
);

  localparam int CW   = $clog2(FRAME_BCLKS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = DATA_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_BCLKS - 1);
  localparam logic [CW-1:0] HALF = CW'(FRAME_BCLKS / 2);
  localparam logic [CW-1:0] TMO  = CW'(3);
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_WAIT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic            lrclk_n;
  logic [15:0]     frame_n;
  logic            drop_first, drop_n;
  logic            timeout;
  logic            running_n;

  // sequencer
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lrclk_n = lrclk;
    frame_n = frame_count;
    drop_n  = drop_first;
    timeout = 1'b0;
    cnt_inc = cnt + 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n   = '0;
        lrclk_n = 1'b0;
        if (enable) begin
          state_n = RUN;
          lrclk_n = 1'b1;
          drop_n  = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          lrclk_n = 1'b1;
          frame_n = frame_count + 16'd1;
          if (!enable) state_n = STOP_WAIT;
        end else begin
          cnt_n   = cnt_inc;
          lrclk_n = (cnt_inc < HALF);
        end
      end
      STOP_WAIT: begin
        lrclk_n = 1'b1;
        // cnt doubles as the flush timeout counter here
        if (right_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
          lrclk_n = 1'b0;
        end else if (cnt == TMO) begin
          state_n = IDLE;
          cnt_n   = '0;
          lrclk_n = 1'b0;
          timeout = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        lrclk_n = 1'b0;
      end
    endcase
    if (state != IDLE && right_valid) drop_n = 1'b0;
  end

  assign running_n = (state_n != IDLE);

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lrclk       <= 1'b0;
      frame_count <= '0;
      drop_first  <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lrclk       <= lrclk_n;
      frame_count <= frame_n;
      drop_first  <= drop_n;
      running     <= running_n;
    end
  end

  logic                  accept;
  logic                  take_left, take_right;
  logic                  push, collide;
  logic [EW-1:0]         push_entry;
  logic                  pop, full, wr_en, drop_full;
  logic                  set_ovf;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_n;
  logic [NW-1:0]         count, count_n;
  logic [EW-1:0]         head_n;

  assign accept     = (state != IDLE);
  assign take_left  = accept & left_valid;
  assign take_right = accept & right_valid & ~drop_first;
  assign push       = take_left | take_right;
  assign collide    = take_left & take_right;
  // left wins a same-cycle collision
  assign push_entry = take_left ? {1'b0, left_data}
                                : {1'b1, right_data};

  assign pop       = out_valid & out_ready;
  assign full      = (count == FULL);
  assign wr_en     = push & (~full | pop);
  assign drop_full = push & full & ~pop;
  assign set_ovf   = collide | drop_full | timeout;

  assign count_n  = count + NW'(wr_en) - NW'(pop);
  assign rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;

  // head register sees a same-cycle write landing in the head slot
  always_comb begin
    head_n = mem[rd_ptr_n];
    if (wr_en && wr_ptr == rd_ptr_n) head_n = push_entry;
  end

  always_ff @(posedge bclk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      out_valid <= (count_n != '0);
      if (count_n != '0) begin
        out_chan <= head_n[EW-1];
        out_data <= head_n[DATA_WIDTH-1:0];
      end
      if (set_ovf) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl.
// Steps the design one bclk at a time and asserts hand-computed values.
module tb_i2s_rx_frame_ctrl;

  logic        rst;
  logic        bclk;
  logic        enable;
  logic        lrclk;
  logic [15:0] left_data, right_data;
  logic        left_valid, right_valid;
  logic [15:0] out_data;
  logic        out_chan, out_valid;
  logic        out_ready;
  logic        overflow, clr_overflow;
  logic        running;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int bpos   = 0;
  int fexp   = 0;
  bit frun   = 0;

  i2s_rx_frame_ctrl #(
    .DATA_WIDTH(16),
    .FRAME_BCLKS(64),
    .FIFO_DEPTH(4)
  ) dut (
    .rst(rst),
    .bclk(bclk),
    .enable(enable),
    .lrclk(lrclk),
    .left_data(left_data),
    .right_data(right_data),
    .left_valid(left_valid),
    .right_valid(right_valid),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .clr_overflow(clr_overflow),
    .running(running),
    .frame_count(frame_count)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bclk);
    #1;
    bpos = (bpos + 1) % 64;
    if (frun && bpos == 0) fexp++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    left_data = '0; right_data = '0;
    left_valid = 1'b0; right_valid = 1'b0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    #12;
    chk("rst_lrclk", lrclk, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_run", running, 0);
    chk("rst_frames", frame_count, 0);

    // start, first right strobe is stale
    @(posedge bclk); #1;
    rst = 1'b0; enable = 1'b1;
    step(); bpos = 0; frun = 1;
    chk("start_lrclk", lrclk, 1);
    chk("start_run", running, 1);
    right_data = 16'hDEAD; right_valid = 1'b1;
    step();
    right_valid = 1'b0;
    chk("drop_first_valid", out_valid, 0);
    chk("drop_first_ovf", overflow, 0);
    while (bpos != 63) begin
      step();
      chk("lrclk_phase", lrclk, (bpos < 32) ? 1 : 0);
    end
    step();
    chk("wrap_lrclk", lrclk, 1);
    chk("frame_one", frame_count, 1);

    // left then right into an empty FIFO
    out_ready = 1'b1;
    left_data = 16'h1234; left_valid = 1'b1;
    step();
    left_valid = 1'b0;
    right_data = 16'hABCD; right_valid = 1'b1;
    chk("l_valid", out_valid, 1);
    chk("l_data", out_data, 16'h1234);
    chk("l_chan", out_chan, 0);
    step();
    right_valid = 1'b0;
    chk("r_valid", out_valid, 1);
    chk("r_data", out_data, 16'hABCD);
    chk("r_chan", out_chan, 1);
    step();
    chk("lr_drained", out_valid, 0);

    // collision: left kept, right dropped
    left_data = 16'h0A0A; left_valid = 1'b1;
    right_data = 16'h0B0B; right_valid = 1'b1;
    step();
    left_valid = 1'b0; right_valid = 1'b0;
    chk("col_data", out_data, 16'h0A0A);
    chk("col_chan", out_chan, 0);
    chk("col_ovf", overflow, 1);
    step();
    chk("col_drained", out_valid, 0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("col_clr", overflow, 0);

    // fill with out_ready low, fifth push dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      left_data = 16'(k * 16'h0101); left_valid = 1'b1;
      step();
      if (k == 4) chk("fill4_ovf", overflow, 0);
    end
    left_valid = 1'b0;
    chk("full_head", out_data, 16'h0101);
    chk("full_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("full_order", out_data, 32'(k * 16'h0101));
    end
    step();
    chk("full_drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);

    // full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      left_data = 16'(k * 16'h1111); left_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    left_data = 16'h5555;
    step();
    out_ready = 1'b0;
    left_data = 16'h6666;
    chk("pp_ovf", overflow, 0);
    chk("pp_head", out_data, 16'h2222);
    step();
    left_valid = 1'b0;
    chk("pp_still_full", overflow, 1);
    clr_overflow = 1'b1; out_ready = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("pp_clr", overflow, 0);
    chk("pp_h3", out_data, 16'h3333);
    step();
    chk("pp_h4", out_data, 16'h4444);
    step();
    chk("pp_h5", out_data, 16'h5555);
    step();
    chk("pp_drained", out_valid, 0);

    // stop requested mid-frame, final right sample flushed
    out_ready = 1'b0;
    while (bpos != 10) step();
    enable = 1'b0;
    while (bpos != 63) step();
    chk("stop_last_lrclk", lrclk, 0);
    chk("stop_last_run", running, 1);
    step(); frun = 0;
    chk("sw_lrclk", lrclk, 1);
    chk("sw_run", running, 1);
    chk("sw_frames", frame_count, fexp);
    step();
    chk("sw_lrclk_hold", lrclk, 1);
    right_data = 16'h5555; right_valid = 1'b1;
    step();
    right_valid = 1'b0;
    chk("flush_valid", out_valid, 1);
    chk("flush_data", out_data, 16'h5555);
    chk("flush_chan", out_chan, 1);
    chk("idle_run", running, 0);
    chk("idle_lrclk", lrclk, 0);
    chk("idle_ovf", overflow, 0);
    left_data = 16'h7777; left_valid = 1'b1;
    step();
    left_valid = 1'b0;
    chk("idle_ignore", out_data, 16'h5555);
    out_ready = 1'b1;
    step();
    chk("idle_drained", out_valid, 0);

    // stop with no right strobe: timeout after 4 cycles
    enable = 1'b1;
    step(); bpos = 0; frun = 1;
    enable = 1'b0;
    while (bpos != 63) step();
    step(); frun = 0;
    chk("tmo_enter", lrclk, 1);
    step(); step(); step();
    chk("tmo_wait", running, 1);
    step();
    chk("tmo_idle", running, 0);
    chk("tmo_ovf", overflow, 1);
    chk("tmo_lrclk", lrclk, 0);
    chk("tmo_frames", frame_count, fexp);

    // reset mid-frame with entries queued
    clr_overflow = 1'b1; enable = 1'b1;
    step(); bpos = 0;
    clr_overflow = 1'b0;
    chk("rs_ovf_clr", overflow, 0);
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      left_data = 16'(k); left_valid = 1'b1;
      step();
    end
    left_valid = 1'b0;
    chk("rs_queued", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_lrclk", lrclk, 0);
    chk("rs_frames", frame_count, 0);
    chk("rs_run", running, 0);
    @(posedge bclk); #1;
    rst = 1'b0;
    step(); bpos = 0;
    chk("rs_restart_lrclk", lrclk, 1);
    chk("rs_restart_run", running, 1);
    chk("rs_restart_empty", out_valid, 0);
    while (bpos != 31) step();
    chk("rs_c31", lrclk, 1);
    step();
    chk("rs_c32", lrclk, 0);
    chk("rs_frames0", frame_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
